// File: rtl/path_checker_pkg.sv
// Shared types and default sizing for the path checker.
// Holds the FSM state encoding and the parameter defaults used by the top and the path memory.
package path_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam int ADDR_W_DEF     = 16;
   localparam int DEPTH_DEF      = 4096;
   localparam int MISS_LIMIT_DEF = 16;

endpackage

// File: rtl/path_mem.sv
// Path storage: DEPTH entries of ADDR_W bits, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module path_mem
   import path_checker_pkg::*;
#(
   parameter  int ADDR_W = ADDR_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              ph2,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [ADDR_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [ADDR_W-1:0] rd_data
);

   logic [ADDR_W-1:0] mem [DEPTH];

   always_ff @(posedge ph2) begin
      if (we) mem[wr_idx] <= wr_data;
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/path_checker.sv
// Watches an address bus and checks that valid samples follow a preloaded path,
// tolerating up to MISS_LIMIT-1 consecutive non-matching samples.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no run active; path memory writable; counters hold
// RUN     | comparing valid samples against path entry at step
// PASS    | whole path seen (loop_en=0) or path_len=0; held until start/abort
// FAIL    | MISS_LIMIT consecutive misses; step frozen at failing index
module path_checker
   import path_checker_pkg::*;
#(
   parameter  int ADDR_W     = ADDR_W_DEF,
   parameter  int DEPTH      = DEPTH_DEF,
   parameter  int MISS_LIMIT = MISS_LIMIT_DEF,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic              ph2,
   input  logic              reset,
   input  logic              ld_we,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [ADDR_W-1:0] ld_data,
   input  logic [IDX_W:0]    path_len,
   input  logic              loop_en,
   input  logic              start,
   input  logic              abort,
   input  logic              sample_vld,
   input  logic [ADDR_W-1:0] address,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic              match,
   output logic [IDX_W-1:0]  step,
   output logic [ADDR_W-1:0] expected,
   output logic [7:0]        misses,
   output logic [15:0]       loops
);

   state_t            state, state_n;
   logic [IDX_W-1:0]  step_n;
   logic [7:0]        misses_n, miss_inc;
   logic [15:0]       loops_n;
   logic              match_n;
   logic [IDX_W:0]    len_q, len_n, last_idx;
   logic              loop_q, loop_n;
   logic              mem_we;

   // The path is frozen while a run is in progress.
   assign mem_we = ld_we && (state != ST_RUN);

   path_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_path_mem (
      .ph2     (ph2),
      .we      (mem_we),
      .wr_idx  (ld_idx),
      .wr_data (ld_data),
      .rd_idx  (step),
      .rd_data (expected)
   );

   assign miss_inc = misses + 8'd1;
   assign last_idx = len_q - 1'b1;

   always_comb begin
      state_n  = state;
      step_n   = step;
      misses_n = misses;
      loops_n  = loops;
      match_n  = 1'b0;
      len_n    = len_q;
      loop_n   = loop_q;

      if (abort) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_RUN: begin
               if (sample_vld) begin
                  if (address == expected) begin
                     match_n  = 1'b1;
                     misses_n = 8'd0;
                     if ({1'b0, step} == last_idx) begin
                        if (loop_q) begin
                           step_n  = '0;
                           loops_n = (loops == 16'hFFFF) ? loops : loops + 16'd1;
                        end else begin
                           state_n = ST_PASS;
                        end
                     end else begin
                        step_n = step + 1'b1;
                     end
                  end else begin
                     misses_n = miss_inc;
                     if (miss_inc == 8'(MISS_LIMIT)) state_n = ST_FAIL;
                  end
               end
            end
            default: begin
               if (start) begin
                  step_n   = '0;
                  misses_n = 8'd0;
                  loops_n  = 16'd0;
                  len_n    = path_len;
                  loop_n   = loop_en;
                  state_n  = (path_len == '0) ? ST_PASS : ST_RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         step   <= '0;
         misses <= 8'd0;
         loops  <= 16'd0;
         match  <= 1'b0;
         len_q  <= '0;
         loop_q <= 1'b0;
      end else begin
         state  <= state_n;
         step   <= step_n;
         misses <= misses_n;
         loops  <= loops_n;
         match  <= match_n;
         len_q  <= len_n;
         loop_q <= loop_n;
      end
   end

   assign busy = (state == ST_RUN);
   assign pass = (state == ST_PASS);
   assign fail = (state == ST_FAIL);

endmodule

// File: tb/tb_path_checker.sv
// Self-checking bench for path_checker: a behavioural model pushes expected
// outputs per driven cycle, a monitor pops and compares after each edge.
module tb_path_checker;

   localparam int ADDR_W     = 16;
   localparam int DEPTH      = 4096;
   localparam int IDX_W      = 12;
   localparam int MISS_LIMIT = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

   logic              ph2 = 1'b0;
   logic              reset;
   logic              ld_we;
   logic [IDX_W-1:0]  ld_idx;
   logic [ADDR_W-1:0] ld_data;
   logic [IDX_W:0]    path_len;
   logic              loop_en;
   logic              start;
   logic              abort;
   logic              sample_vld;
   logic [ADDR_W-1:0] address;
   logic              busy, pass, fail, match;
   logic [IDX_W-1:0]  step;
   logic [ADDR_W-1:0] expected;
   logic [7:0]        misses;
   logic [15:0]       loops;

   path_checker dut (
      .ph2        (ph2),
      .reset      (reset),
      .ld_we      (ld_we),
      .ld_idx     (ld_idx),
      .ld_data    (ld_data),
      .path_len   (path_len),
      .loop_en    (loop_en),
      .start      (start),
      .abort      (abort),
      .sample_vld (sample_vld),
      .address    (address),
      .busy       (busy),
      .pass       (pass),
      .fail       (fail),
      .match      (match),
      .step       (step),
      .expected   (expected),
      .misses     (misses),
      .loops      (loops)
   );

   always #5 ph2 = ~ph2;

   typedef struct packed {
      logic             match;
      logic [IDX_W-1:0] step;
      logic [7:0]       misses;
      logic [15:0]      loops;
      logic             busy;
      logic             pass;
      logic             fail;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passed = 0;

   // reference model state
   int              m_state, m_step, m_misses, m_loops, m_len;
   logic            m_lp;
   logic [15:0]     m_mem [0:15];

   task automatic model_reset();
      m_state = M_IDLE; m_step = 0; m_misses = 0; m_loops = 0; m_len = 0; m_lp = 1'b0;
   endtask

   task automatic drive(input logic we_i, input int idx_i, input logic [15:0] data_i,
                        input logic st_i, input logic ab_i, input logic vld_i,
                        input logic [15:0] addr_i);
      exp_t e;
      @(negedge ph2);
      ld_we = we_i; ld_idx = IDX_W'(idx_i); ld_data = data_i;
      start = st_i; abort = ab_i; sample_vld = vld_i; address = addr_i;
      e.match = 1'b0;
      if (we_i && m_state != M_RUN) m_mem[idx_i[3:0]] = data_i;
      if (ab_i) begin
         m_state = M_IDLE;
      end else if (m_state == M_RUN) begin
         if (vld_i) begin
            if (addr_i === m_mem[m_step[3:0]]) begin
               e.match  = 1'b1;
               m_misses = 0;
               if (m_step == m_len - 1) begin
                  if (m_lp) begin
                     m_step = 0;
                     if (m_loops < 65535) m_loops++;
                  end else begin
                     m_state = M_PASS;
                  end
               end else begin
                  m_step++;
               end
            end else begin
               m_misses++;
               if (m_misses == MISS_LIMIT) m_state = M_FAIL;
            end
         end
      end else if (st_i) begin
         m_step = 0; m_misses = 0; m_loops = 0;
         m_len = int'(path_len); m_lp = loop_en;
         m_state = (path_len == 0) ? M_PASS : M_RUN;
      end
      e.step   = IDX_W'(m_step);
      e.misses = 8'(m_misses);
      e.loops  = 16'(m_loops);
      e.busy   = (m_state == M_RUN);
      e.pass   = (m_state == M_PASS);
      e.fail   = (m_state == M_FAIL);
      sb_q.push_back(e);
      @(posedge ph2);
      #2;
      ld_we = 1'b0; start = 1'b0; abort = 1'b0; sample_vld = 1'b0;
   endtask

   always @(posedge ph2) begin
      exp_t e, a;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         a = {match, step, misses, loops, busy, pass, fail};
         checks++;
         if (a !== e)
            $display("FAIL sb_cycle t=%0t: got m=%b st=%0d mi=%0d lp=%0d b/p/f=%b%b%b exp m=%b st=%0d mi=%0d lp=%0d b/p/f=%b%b%b",
                     $time, a.match, a.step, a.misses, a.loops, a.busy, a.pass, a.fail,
                     e.match, e.step, e.misses, e.loops, e.busy, e.pass, e.fail);
         else
            passed++;
      end
   end

   task automatic load_path3();
      drive(1, 0, 16'hFFFC, 0, 0, 0, 0);
      drive(1, 1, 16'hFFFD, 0, 0, 0, 0);
      drive(1, 2, 16'hFA62, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge ph2);
      #1;
      checks++;
      if ({busy, pass, fail, match} !== 4'b0000) $display("FAIL reset_flags: got %b exp 0000", {busy, pass, fail, match});
      else passed++;
      checks++;
      if ({step, misses, loops} !== '0) $display("FAIL reset_counts: got step=%0d misses=%0d loops=%0d exp 0", step, misses, loops);
      else passed++;
      @(negedge ph2);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_pass_path();
      logic [15:0] seq [3];
      int n_match = 0;
      seq[0] = 16'hFFFC; seq[1] = 16'hFFFD; seq[2] = 16'hFA62;
      load_path3();
      path_len = 13'd3; loop_en = 1'b0;
      drive(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 1, seq[i]);
         if (match) n_match++;
         drive(0, 0, 0, 0, 0, 0, 0);
      end
      checks++;
      if (n_match !== 3) $display("FAIL pass_match_count: got %0d exp 3", n_match); else passed++;
      checks++;
      if (pass !== 1'b1 || step !== 12'd2) $display("FAIL pass_final: got pass=%b step=%0d exp pass=1 step=2", pass, step);
      else passed++;
   endtask

   task automatic test_fail_path();
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 16'hFFFC);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 0, 1, 16'h1234);
         if (i == 14) begin
            checks++;
            if (fail !== 1'b0 || misses !== 8'd15) $display("FAIL fail_early: got fail=%b misses=%0d exp fail=0 misses=15", fail, misses);
            else passed++;
         end
      end
      checks++;
      if (fail !== 1'b1 || step !== 12'd1 || misses !== 8'd16)
         $display("FAIL fail_final: got fail=%b step=%0d misses=%0d exp fail=1 step=1 misses=16", fail, step, misses);
      else passed++;
      // recovery: 15 misses then the expected address
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 16'hFFFC);
      for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0, 1, 16'h0000);
      drive(0, 0, 0, 0, 0, 1, 16'hFFFD);
      checks++;
      if (misses !== 8'd0 || busy !== 1'b1 || step !== 12'd2)
         $display("FAIL fail_recover: got misses=%0d busy=%b step=%0d exp misses=0 busy=1 step=2", misses, busy, step);
      else passed++;
      drive(0, 0, 0, 1, 0, 0, 0);  // start in RUN is ignored
      drive(0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_loop();
      drive(1, 0, 16'h1111, 0, 0, 0, 0);
      drive(1, 1, 16'h2222, 0, 0, 0, 0);
      path_len = 13'd2; loop_en = 1'b1;
      drive(0, 0, 0, 1, 0, 0, 0);
      loop_en = 1'b0;  // latched at start
      for (int r = 0; r < 3; r++) begin
         drive(0, 0, 0, 0, 0, 1, 16'h1111);
         drive(0, 0, 0, 0, 0, 0, 0);
         drive(0, 0, 0, 0, 0, 1, 16'h2222);
      end
      checks++;
      if (loops !== 16'd3 || busy !== 1'b1 || step !== 12'd0)
         $display("FAIL loop_final: got loops=%0d busy=%b step=%0d exp loops=3 busy=1 step=0", loops, busy, step);
      else passed++;
      drive(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (busy !== 1'b0 || loops !== 16'd3) $display("FAIL loop_abort_hold: got busy=%b loops=%0d exp busy=0 loops=3", busy, loops);
      else passed++;
   endtask

   task automatic test_reset_in_run();
      load_path3();
      path_len = 13'd3; loop_en = 1'b0;
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 16'hFFFC);
      @(negedge ph2);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({busy, pass, fail, match, step, misses, loops} !== '0)
         $display("FAIL async_reset: got busy=%b pass=%b fail=%b match=%b step=%0d misses=%0d loops=%0d exp all 0",
                  busy, pass, fail, match, step, misses, loops);
      else passed++;
      #1 reset = 1'b0;
      model_reset();
      path_len = '0;
      drive(0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (pass !== 1'b1 || busy !== 1'b0) $display("FAIL zero_len: got pass=%b busy=%b exp pass=1 busy=0", pass, busy);
      else passed++;
   endtask

   task automatic test_abort_and_load();
      path_len = 13'd3;
      drive(0, 0, 0, 1, 1, 0, 0);
      checks++;
      if (busy !== 1'b0 || pass !== 1'b0) $display("FAIL start_abort: got busy=%b pass=%b exp 0 0", busy, pass);
      else passed++;
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(1, 0, 16'hBEEF, 0, 0, 0, 0);
      checks++;
      if (expected !== 16'hFFFC) $display("FAIL run_write_drop: got %h exp fffc", expected);
      else passed++;
      drive(0, 0, 0, 0, 1, 0, 0);
      drive(1, 0, 16'hABCD, 0, 0, 0, 0);
      checks++;
      if (expected !== 16'hABCD) $display("FAIL idle_write: got %h exp abcd", expected);
      else passed++;
   endtask

   initial begin
      ld_we = 1'b0; ld_idx = '0; ld_data = '0; path_len = '0; loop_en = 1'b0;
      start = 1'b0; abort = 1'b0; sample_vld = 1'b0; address = '0;
      model_reset();
      test_reset();
      test_pass_path();
      test_fail_path();
      test_loop();
      test_reset_in_run();
      test_abort_and_load();
      repeat (2) @(posedge ph2);
      #3;
      if (sb_q.size() != 0) begin
         checks++;
         $display("FAIL sb_drain: got %0d entries left exp 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
